// File: rtl/arm7_mem_pkg.sv
// Shared types and widths for the data-memory arbiter: FSM states, requester id
// and the registered request record.
package arm7_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic              write;
    logic              is_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic word_misaligned(mem_req_t r);
    return !r.is_byte && (r.addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The grant is combinational while enabled.
// The favour pointer moves only when a grant is taken.
module rr_arbiter_2
  import arm7_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    enable,
  input  logic    valid0,
  input  logic    valid1,
  output logic    grant0,
  output logic    grant1,
  output req_id_t winner
);

  req_id_t favour;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant0 = (favour == 1'b0);
        grant1 = (favour == 1'b1);
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign winner = req_id_t'(grant1);

  // A grant implies a handshake, because ready is the grant itself.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst)         favour <= 1'b0;
    else if (grant0) favour <= 1'b1;
    else if (grant1) favour <= 1'b0;
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates two load/store requesters onto one data_memory, one transaction at a time.
// Optional MEM_ALIGN_CHECK_EN faults misaligned word accesses instead of issuing them.
module data_memory_arbiter
  import arm7_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic              req0_byte,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic              req1_byte,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_write_word_en,
  output logic              mem_write_byte_en,
  output logic              mem_read_word_en,
  output logic              mem_read_byte_en,
  output logic [ADDR_W-1:0] mem_write_word_address,
  output logic [ADDR_W-1:0] mem_write_byte_address,
  output logic [ADDR_W-1:0] mem_read_word_address,
  output logic [ADDR_W-1:0] mem_read_byte_address,
  output logic [DATA_W-1:0] mem_write_word_data,
  output logic [7:0]        mem_write_byte_data,
  input  logic [DATA_W-1:0] mem_read_word_data,
  input  logic [7:0]        mem_read_byte_data
);

  state_t   state;
  mem_req_t req_q;
  req_id_t  id_q;
  logic     misalign_q;

  logic     arb_en, grant0, grant1, handshake, misalign_in;
  req_id_t  winner;
  mem_req_t req_in;

  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1),
    .winner (winner)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign handshake  = grant0 || grant1;

  assign req_in = winner ? '{req1_write, req1_byte, req1_addr, req1_wdata}
                         : '{req0_write, req0_byte, req0_addr, req0_wdata};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = word_misaligned(req_in);
`else
  assign misalign_in = 1'b0;
`endif

  // Response is launched from ISSUE (store or fault) or from WAIT (load data).
  logic              rsp_fire, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    case (state)
      ISSUE: if (req_q.write || misalign_q) begin
        rsp_fire = 1'b1;
        rsp_err  = misalign_q;
      end
      WAIT: begin
        rsp_fire = 1'b1;
        rsp_data = req_q.is_byte ? {{(DATA_W-8){1'b0}}, mem_read_byte_data}
                                 : mem_read_word_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      req_q                  <= '0;
      id_q                   <= 1'b0;
      misalign_q             <= 1'b0;
      rsp0_valid             <= 1'b0;
      rsp0_rdata             <= '0;
      rsp0_err               <= 1'b0;
      rsp1_valid             <= 1'b0;
      rsp1_rdata             <= '0;
      rsp1_err               <= 1'b0;
      mem_write_word_en      <= 1'b0;
      mem_write_byte_en      <= 1'b0;
      mem_read_word_en       <= 1'b0;
      mem_read_byte_en       <= 1'b0;
      mem_write_word_address <= '0;
      mem_write_byte_address <= '0;
      mem_read_word_address  <= '0;
      mem_read_byte_address  <= '0;
      mem_write_word_data    <= '0;
      mem_write_byte_data    <= '0;
    end else begin
      // Enables and responses are single-cycle pulses; idle values are zero.
      mem_write_word_en      <= 1'b0;
      mem_write_byte_en      <= 1'b0;
      mem_read_word_en       <= 1'b0;
      mem_read_byte_en       <= 1'b0;
      mem_write_word_address <= '0;
      mem_write_byte_address <= '0;
      mem_read_word_address  <= '0;
      mem_read_byte_address  <= '0;
      mem_write_word_data    <= '0;
      mem_write_byte_data    <= '0;
      rsp0_valid             <= rsp_fire && (id_q == 1'b0);
      rsp0_rdata             <= (id_q == 1'b0) ? rsp_data : '0;
      rsp0_err               <= rsp_fire && (id_q == 1'b0) && rsp_err;
      rsp1_valid             <= rsp_fire && (id_q == 1'b1);
      rsp1_rdata             <= (id_q == 1'b1) ? rsp_data : '0;
      rsp1_err               <= rsp_fire && (id_q == 1'b1) && rsp_err;

      case (state)
        IDLE: if (handshake) begin
          req_q      <= req_in;
          id_q       <= winner;
          misalign_q <= misalign_in;
          state      <= ISSUE;
          if (!misalign_in) begin
            case ({req_in.write, req_in.is_byte})
              2'b10: begin
                mem_write_word_en      <= 1'b1;
                mem_write_word_address <= req_in.addr;
                mem_write_word_data    <= req_in.wdata;
              end
              2'b11: begin
                mem_write_byte_en      <= 1'b1;
                mem_write_byte_address <= req_in.addr;
                mem_write_byte_data    <= req_in.wdata[7:0];
              end
              2'b00: begin
                mem_read_word_en       <= 1'b1;
                mem_read_word_address  <= req_in.addr;
              end
              default: begin
                mem_read_byte_en       <= 1'b1;
                mem_read_byte_address  <= req_in.addr;
              end
            endcase
          end
        end
        ISSUE:   state <= (req_q.write || misalign_q) ? RESP : WAIT;
        WAIT:    state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a byte-array memory emulator,
// plus a transaction-level reference model for grant order, latency and data.
module tb_data_memory_arbiter;
  import arm7_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_write, req0_byte;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_write, req1_byte;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en;
  logic [31:0] mem_write_word_address, mem_write_byte_address;
  logic [31:0] mem_read_word_address, mem_read_byte_address;
  logic [31:0] mem_write_word_data, mem_read_word_data;
  logic [7:0]  mem_write_byte_data, mem_read_byte_data;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_byte(req0_byte), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_byte(req1_byte), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_write_word_en(mem_write_word_en), .mem_write_byte_en(mem_write_byte_en),
    .mem_read_word_en(mem_read_word_en), .mem_read_byte_en(mem_read_byte_en),
    .mem_write_word_address(mem_write_word_address),
    .mem_write_byte_address(mem_write_byte_address),
    .mem_read_word_address(mem_read_word_address),
    .mem_read_byte_address(mem_read_byte_address),
    .mem_write_word_data(mem_write_word_data), .mem_write_byte_data(mem_write_byte_data),
    .mem_read_word_data(mem_read_word_data), .mem_read_byte_data(mem_read_byte_data)
  );

  typedef struct {
    bit          write;
    bit          is_byte;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] emu_mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];
  bit          favour_m;
  bit          pend_rd_w, pend_rd_b;
  logic [31:0] pend_w;
  logic [7:0]  pend_b;
  txn_t        cur [2];
  bit          pend [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] emu_rd8(input logic [31:0] a);
    return emu_mem.exists(a) ? emu_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd8(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic any_out();
    return |{req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid,
             rsp1_rdata, rsp1_err, mem_write_word_en, mem_write_byte_en,
             mem_read_word_en, mem_read_byte_en, mem_write_word_address,
             mem_write_byte_address, mem_read_word_address, mem_read_byte_address,
             mem_write_word_data, mem_write_byte_data};
  endfunction

  // Advance to the next falling edge and act as the data_memory.
  // Read data appears one cycle after the enable; otherwise the read bus carries junk.
  task automatic step();
    @(negedge clk);
    mem_read_word_data = pend_rd_w ? pend_w : $urandom;
    mem_read_byte_data = pend_rd_b ? pend_b : 8'($urandom);
    pend_rd_w = 1'b0;
    pend_rd_b = 1'b0;
    if (mem_write_word_en)
      for (int i = 0; i < 4; i++) emu_mem[mem_write_word_address + 32'(i)] = mem_write_word_data[8*i +: 8];
    if (mem_write_byte_en) emu_mem[mem_write_byte_address] = mem_write_byte_data;
    if (mem_read_word_en) begin
      pend_rd_w = 1'b1;
      for (int i = 0; i < 4; i++) pend_w[8*i +: 8] = emu_rd8(mem_read_word_address + 32'(i));
    end
    if (mem_read_byte_en) begin
      pend_rd_b = 1'b1;
      pend_b    = emu_rd8(mem_read_byte_address);
    end
    check("en_onehot", 32'($countones({mem_write_word_en, mem_write_byte_en,
                                       mem_read_word_en, mem_read_byte_en}) <= 1), 32'd1);
  endtask

  task automatic drive(input bit v0, input bit v1, input txn_t t0, input txn_t t1);
    req0_valid = v0; req0_write = t0.write; req0_byte = t0.is_byte;
    req0_addr  = t0.addr; req0_wdata = t0.wdata;
    req1_valid = v1; req1_write = t1.write; req1_byte = t1.is_byte;
    req1_addr  = t1.addr; req1_wdata = t1.wdata;
  endtask

  // Present requests in IDLE and follow the granted transaction to its response.
  task automatic issue(input bit v0, input bit v1, input txn_t t0, input txn_t t1,
                       output bit won);
    txn_t        t;
    bit          exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_en;
    int          lat;
    won      = (v0 && v1) ? favour_m : v1;
    favour_m = !won;
    drive(v0, v1, t0, t1);
    #1;
    check("ready0", 32'(req0_ready), 32'(v0 && !won));
    check("ready1", 32'(req1_ready), 32'(v1 && won));
    t       = won ? t1 : t0;
    exp_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    exp_err = !t.is_byte && (t.addr[1:0] != 2'b00);
`endif
    exp_data = '0;
    lat      = 2;
    if (!exp_err && t.write) begin
      if (t.is_byte) ref_mem[t.addr] = t.wdata[7:0];
      else for (int i = 0; i < 4; i++) ref_mem[t.addr + 32'(i)] = t.wdata[8*i +: 8];
    end else if (!exp_err) begin
      lat = 3;
      if (t.is_byte) exp_data = {24'h0, ref_rd8(t.addr)};
      else for (int i = 0; i < 4; i++) exp_data[8*i +: 8] = ref_rd8(t.addr + 32'(i));
    end
    case ({t.write, t.is_byte})
      2'b10:   exp_en = 4'b1000;
      2'b11:   exp_en = 4'b0100;
      2'b00:   exp_en = 4'b0010;
      default: exp_en = 4'b0001;
    endcase
    if (exp_err) exp_en = 4'b0000;

    step();
    if (won) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    check("issue_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("issue_en", 32'({mem_write_word_en, mem_write_byte_en, mem_read_word_en,
                           mem_read_byte_en}), 32'(exp_en));
    case (exp_en)
      4'b1000: begin
        check("ww_addr", mem_write_word_address, t.addr);
        check("ww_data", mem_write_word_data, t.wdata);
      end
      4'b0100: begin
        check("wb_addr", mem_write_byte_address, t.addr);
        check("wb_data", 32'(mem_write_byte_data), 32'(t.wdata[7:0]));
      end
      4'b0010: check("rw_addr", mem_read_word_address, t.addr);
      4'b0001: check("rb_addr", mem_read_byte_address, t.addr);
      default: ;
    endcase

    for (int k = 2; k <= lat + 1; k++) begin
      step();
      check("post_en", 32'({mem_write_word_en, mem_write_byte_en, mem_read_word_en,
                           mem_read_byte_en}), 32'd0);
      if (k == lat) begin
        check("rsp_valid", 32'({rsp1_valid, rsp0_valid}), won ? 32'd2 : 32'd1);
        check("rsp_rdata", won ? rsp1_rdata : rsp0_rdata, exp_data);
        check("rsp_err", 32'(won ? rsp1_err : rsp0_err), 32'(exp_err));
        check("rsp_other", won ? 32'({rsp0_rdata, rsp0_err}) : 32'({rsp1_rdata, rsp1_err}), 32'd0);
      end else begin
        check("no_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
        check("no_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
      end
    end
  endtask

  function automatic txn_t mk(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.write = w; t.is_byte = b; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.write   = 1'($urandom_range(0, 1));
    t.is_byte = 1'($urandom_range(0, 1));
    t.addr    = 32'h2000 + 32'($urandom_range(0, 15));
    if (!t.is_byte && $urandom_range(0, 3) != 0) t.addr[1:0] = 2'b00;
    t.wdata   = $urandom;
    return t;
  endfunction

  initial begin
    txn_t idle_t, a, b;
    bit   won;
    idle_t    = mk(0, 0, 32'h0, 32'h0);
    pend_rd_w = 1'b0;
    pend_rd_b = 1'b0;
    favour_m  = 1'b0;
    mem_read_word_data = '0;
    mem_read_byte_data = '0;
    drive(0, 0, idle_t, idle_t);
    rst = 1'b1;
    step();
    step();
    check("reset_outputs", 32'(any_out()), 32'd0);
    rst = 1'b0;

    // Both requesters hold valid: grants must alternate 0,1,0,1.
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r]) begin
          cur[r]  = mk(1, 0, 32'h3000 + 32'(16*i + 4*r), 32'hC0DE_0000 + 32'(i));
          pend[r] = 1;
        end
      issue(1, 1, cur[0], cur[1], won);
      pend[won] = 0;
    end
    if (pend[0]) issue(1, 0, cur[0], idle_t, won);
    if (pend[1]) issue(0, 1, idle_t, cur[1], won);

    // Directed word/byte stores and loads, including the 0x1002 alignment case.
    issue(1, 0, mk(1, 0, 32'h1000, 32'hDEADBEEF), idle_t, won);
    issue(0, 1, idle_t, mk(0, 0, 32'h1000, 32'h0), won);
    issue(1, 0, mk(1, 1, 32'h1001, 32'h0000_00AA), idle_t, won);
    issue(0, 1, idle_t, mk(1, 1, 32'h1003, 32'hFFFF_FF55), won);
    issue(1, 0, mk(0, 1, 32'h1001, 32'h0), idle_t, won);
    issue(0, 1, idle_t, mk(0, 1, 32'h1003, 32'h0), won);
    issue(1, 0, mk(0, 0, 32'h1002, 32'h0), idle_t, won);

    // Reset during WAIT of a req0 load: response dropped, pointer back to 0.
    favour_m = 1'b1;
    drive(1, 0, mk(0, 0, 32'h1000, 32'h0), idle_t);
    #1;
    check("pre_rst_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    drive(1, 1, mk(0, 1, 32'h1001, 32'h0), mk(0, 1, 32'h1003, 32'h0));
    #1;
    check("mid_rst_outputs", 32'(any_out()), 32'd0);
    step();
    check("mid_rst_hold", 32'(any_out()), 32'd0);
    rst      = 1'b0;
    favour_m = 1'b0;
    issue(1, 1, mk(0, 1, 32'h1001, 32'h0), mk(0, 1, 32'h1003, 32'h0), won);
    issue(0, 1, idle_t, mk(0, 1, 32'h1003, 32'h0), won);

    // Randomized traffic; a losing request keeps its payload until granted.
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          cur[r]  = rand_txn();
          pend[r] = 1;
        end
      if (!pend[0] && !pend[1]) begin
        a = rand_txn();
        b = idle_t;
        cur[i % 2]  = a;
        pend[i % 2] = 1;
      end
      issue(pend[0], pend[1], pend[0] ? cur[0] : idle_t, pend[1] ? cur[1] : idle_t, won);
      pend[won] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a request pending.
REQ-005 reqN_ready  output  1  request N accepted this cycle (handshake when valid&&ready).
REQ-006 reqN_write  input  1  1=store, 0=load.
REQ-007 reqN_byte  input  1  1=byte access, 0=word access.
REQ-008 reqN_addr  input  32  byte address.
REQ-009 reqN_wdata  input  32  store data; byte stores use bits [7:0].
REQ-010 rspN_valid  output  1  one-cycle response pulse to requester N.
REQ-011 rspN_rdata  output  32  load data; byte loads zero-extended; 0 for stores.
REQ-012 rspN_err  output  1  alignment fault flag, valid with rspN_valid.
REQ-013 mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en  output  1 each  data_memory enables.
REQ-014 mem_write_word_address, mem_write_byte_address, mem_read_word_address, mem_read_byte_address  output  32 each  data_memory addresses.
REQ-015 mem_write_word_data  output  32, mem_write_byte_data  output  8  data_memory store data.
REQ-016 mem_read_word_data  input  32, mem_read_byte_data  input  8  data_memory load data, valid the cycle after the read enable edge.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: reqN_ready asserted combinationally for the arbitration winner only; never in any other state.
REQ-019 Only one valid: that requester wins; both valid: the one not granted last wins (round-robin).
REQ-020 On handshake in cycle T: request fields registered, winner id stored, next state ISSUE.
REQ-021 ISSUE (T+1): exactly one mem enable high, selected by write/byte; addresses and data from the registered request; all other enables 0.
REQ-022 ISSUE -> RESP for stores; ISSUE -> WAIT for loads.
REQ-023 WAIT (T+2): capture mem_read_word_data or {24'b0, mem_read_byte_data}; -> RESP.
REQ-024 RESP: rspN_valid=1 for the stored id only, for exactly one cycle; -> IDLE. Store response at T+2, load response at T+3.
REQ-025 rspN_rdata and rspN_err hold their value only while rspN_valid=1; 0 otherwise.
REQ-026 Requesters hold valid and payload stable until ready; a valid without ready is not consumed.
REQ-027 No response backpressure; requesters shall accept rspN_valid when it arrives.
REQ-028 All mem_* outputs are registered; enables are 0 in IDLE, WAIT and RESP.

Reset
REQ-029 While rst=1: state IDLE, all outputs 0, round-robin pointer favours requester 0.
REQ-030 Reset mid-transaction drops it: no response is issued and no further mem enable is asserted.

Configuration
REQ-031 Macro MEM_ALIGN_CHECK_EN defined: a word access with addr[1:0]!=0 asserts no mem enable; RESP follows ISSUE with err=1 and rdata=0 (response at T+2).
REQ-032 MEM_ALIGN_CHECK_EN undefined: the address is passed through unmodified; rspN_err is tied to 0.

Structure
REQ-033 Package arm7_mem_pkg holds the FSM state enum, the requester-id type, and ADDR_W=32 and DATA_W=32.
REQ-034 Sub-module rr_arbiter_2 holds the 2-way round-robin grant logic and pointer; it updates on handshake only.

Verification
REQ-035 req0 stores word 0xDEADBEEF @0x1000 -> mem_write_word_en high one cycle at T+1 with addr 0x1000; rsp0_valid at T+2 with rdata=0.
REQ-036 req1 loads word @0x1000 -> mem_read_word_en at T+1; rsp1_valid at T+3 with rdata=0xDEADBEEF.
REQ-037 Byte stores 0xAA@0x1001 and 0x55@0x1003, then byte loads from both -> rdata 0x000000AA and 0x00000055.
REQ-038 Both valid continuously for 4 transactions after reset -> grant order 0,1,0,1; never both ready in one cycle.
REQ-039 MEM_ALIGN_CHECK_EN defined, word load @0x1002 -> no mem enable, rsp err=1 and rdata=0 at T+2; undefined -> normal load, err=0.
REQ-040 rst asserted during WAIT -> no rspN_valid, all outputs 0 next cycle, next simultaneous request granted to requester 0.
